// File: rtl/mmio_pkg.sv
// mmio_pkg: address-map constants, FSM states and offset decoder shared by the MMIO bridge
package mmio_pkg;

    localparam logic [7:0] OUT_OFS  = 8'h00;
    localparam logic [7:0] IN_OFS   = 8'h40;
    localparam logic [7:0] STAT_OFS = 8'h80;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef enum logic [1:0] {REG_OUT, REG_IN, REG_STAT, REG_NONE} region_t;

    typedef struct packed {
        region_t    region;
        logic [3:0] idx;
        logic       err;
    } dec_t;

    // ofs is the 32-bit unsigned distance from the window base, so addresses below the base wrap high
    function automatic dec_t decode(input logic [31:0] ofs, input int n_out, input int n_in);
        dec_t d;
        d.idx    = ofs[5:2];
        d.region = (ofs[7:6] == OUT_OFS[7:6]) ? REG_OUT :
                   (ofs[7:6] == IN_OFS[7:6])  ? REG_IN  :
                   (ofs[7:0] == STAT_OFS)     ? REG_STAT : REG_NONE;
        d.err    = (ofs[31:8] != '0) || (ofs[1:0] != 2'b00) || (d.region == REG_NONE) ||
                   (d.region == REG_OUT && int'(d.idx) >= n_out) ||
                   (d.region == REG_IN && int'(d.idx) >= n_in);
        return d;
    endfunction

endpackage

// File: rtl/mmio_bridge_edge_capture.sv
// edge_capture: registered rising-edge detector feeding a sticky flag with clear, set wins
module edge_capture (
    input  logic clk,
    input  logic rst,
    input  logic evt_i,
    input  logic clr_i,
    output logic flag_o
);

    logic evt_q, flag_q;

    // A fresh rising edge overrides a clear landing on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_q  <= 1'b0;
            flag_q <= 1'b0;
        end else begin
            evt_q  <= evt_i;
            flag_q <= (evt_i & ~evt_q) | (flag_q & ~clr_i);
        end
    end

    assign flag_o = flag_q;

endmodule

// File: rtl/mmio_bridge.sv
// mmio_bridge: valid/ready MMIO bridge to output registers, input channels and sticky event flags
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter int          N_OUT       = 4,
    parameter int          N_IN        = 4,
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FC00,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                req_we,
    input  logic [31:0]         req_addr,
    input  logic [31:0]         req_wdata,
    output logic                req_ready,
    output logic                rsp_valid,
    output logic [31:0]         rsp_rdata,
    output logic                rsp_err,
    input  logic [N_IN*32-1:0]  in_data,
    input  logic [N_IN-1:0]     evt_in,
    output logic [N_OUT*32-1:0] out_data,
    output logic [N_OUT-1:0]    out_wstb
);

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                we_q;
    logic [31:0]         addr_q, wdata_q;
    logic                req_ready_q, rsp_valid_q, rsp_err_q;
    logic [31:0]         rsp_rdata_q;
    logic [N_OUT*32-1:0] out_q;
    logic [N_OUT-1:0]    wstb_q, wr_d;
    logic [N_IN-1:0]     flags, clr_d;
    logic                cur_we, commit_d, err_d;
    logic [31:0]         cur_addr, cur_wdata, rd_out, rd_in, rdata_d;
    dec_t                dec;

    // Decode the access that enters RESP on this edge: the live request when there are no wait states
    always_comb begin
        cur_we    = (state_q == IDLE) ? req_we : we_q;
        cur_addr  = (state_q == IDLE) ? req_addr : addr_q;
        cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
        dec       = decode(cur_addr - BASE_ADDR, N_OUT, N_IN);
        commit_d  = (state_q == IDLE && req_valid && WAIT_CYCLES == 0) || (state_q == WAIT && cnt_q == 4'd0);
        err_d     = dec.err || (cur_we && dec.region == REG_IN);
        rd_out    = '0;
        rd_in     = '0;
        wr_d      = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (dec.idx == 4'(i)) begin
                rd_out  = out_q[i*32 +: 32];
                wr_d[i] = commit_d && cur_we && !err_d && dec.region == REG_OUT;
            end
        end
        for (int i = 0; i < N_IN; i++) begin
            if (dec.idx == 4'(i)) rd_in = in_data[i*32 +: 32];
        end
        rdata_d = (err_d || cur_we) ? '0 :
                  (dec.region == REG_OUT) ? rd_out :
                  (dec.region == REG_IN)  ? rd_in  : 32'(flags);
        clr_d   = (commit_d && !err_d && dec.region == REG_STAT) ? (cur_we ? cur_wdata[N_IN-1:0] : '1) : '0;
    end

    // Request/response FSM with registered handshake, response and output-register commit
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            out_q       <= '0;
            wstb_q      <= '0;
        end else begin
            rsp_valid_q <= commit_d;
            rsp_err_q   <= commit_d && err_d;
            rsp_rdata_q <= commit_d ? rdata_d : '0;
            wstb_q      <= wr_d;
            for (int i = 0; i < N_OUT; i++) begin
                if (wr_d[i]) out_q[i*32 +: 32] <= cur_wdata;
            end
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_we;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        cnt_q       <= CNT_INIT;
                        state_q     <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                        req_ready_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) state_q <= RESP;
                    else cnt_q <= cnt_q - 4'd1;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    for (genvar i = 0; i < N_IN; i++) begin : g_evt
        edge_capture u_evt (
            .clk   (clk),
            .rst   (rst),
            .evt_i (evt_in[i]),
            .clr_i (clr_d[i]),
            .flag_o(flags[i])
        );
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign out_data  = out_q;
    assign out_wstb  = wstb_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: directed tests plus a transaction-level model checked every cycle
module tb_mmio_bridge;

    localparam logic [31:0] B   = 32'hFFFF_FC00;
    localparam int          W0  = 1;
    localparam int          WCS [3] = '{W0, 0, 3};

    logic         clk = 1'b0, rst = 1'b1, we = 1'b0;
    logic [31:0]  addr = '0, wdata = '0;
    logic [127:0] in_data = '0;
    logic [3:0]   evt_in = '0;
    logic [2:0]   v = '0, rdy, rv, rerr;
    logic [31:0]  rdat [3];
    logic [127:0] od [3];
    logic [3:0]   ws [3];
    int           checks = 0, fails = 0;
    int           npulse [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    // Instance 0 is the main DUT (one wait state); 1 and 2 measure zero and three wait states
    for (genvar g = 0; g < 3; g++) begin : g_dut
        mmio_bridge #(.N_OUT(4), .N_IN(4), .BASE_ADDR(B), .WAIT_CYCLES(WCS[g])) u_dut (
            .clk(clk), .rst(rst), .req_valid(v[g]), .req_we(we), .req_addr(addr), .req_wdata(wdata),
            .req_ready(rdy[g]), .rsp_valid(rv[g]), .rsp_rdata(rdat[g]), .rsp_err(rerr[g]),
            .in_data(in_data), .evt_in(g == 0 ? evt_in : 4'b0), .out_data(od[g]), .out_wstb(ws[g]));
    end

    always @(posedge clk) for (int i = 0; i < 3; i++) if (rv[i]) npulse[i]++;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Transaction model of instance 0: accepted request completes W0 edges after acceptance
    int          ph = 0, rem = 0;
    logic        mok = 1'b0, mwe;
    logic [31:0] ma, md;
    logic [31:0] mout [4];
    logic [3:0]  mflag, mprev, e_ws;
    logic        e_valid, e_err;
    logic [31:0] e_rd;

    always @(posedge clk) begin
        logic [3:0]  rise, clr;
        logic [31:0] ofs;
        int          ch;
        if (rst) begin
            ph = 0; mflag = '0; mprev = '0; mok = 1'b1;
            for (int i = 0; i < 4; i++) mout[i] = '0;
            e_valid = 1'b0; e_err = 1'b0; e_rd = '0; e_ws = '0;
        end else begin
            rise = evt_in & ~mprev;
            mprev = evt_in;
            clr = '0;
            e_valid = 1'b0; e_err = 1'b0; e_rd = '0; e_ws = '0;
            if (ph == 2) ph = 0;
            else if (ph == 0 && v[0]) begin
                mwe = we; ma = addr; md = wdata; rem = W0; ph = 1;
            end else if (ph == 1) rem--;
            if (ph == 1 && rem == 0) begin
                ph = 2;
                e_valid = 1'b1;
                ofs = ma - B;
                if (ofs >= 256 || ma[1:0] != 2'b00) e_err = 1'b1;
                else if (ofs < 16) begin
                    ch = int'(ofs / 4);
                    if (mwe) begin mout[ch] = md; e_ws[ch] = 1'b1; end
                    else e_rd = mout[ch];
                end else if (ofs >= 64 && ofs < 80) begin
                    if (mwe) e_err = 1'b1;
                    else e_rd = in_data[(ofs - 64) / 4 * 32 +: 32];
                end else if (ofs == 128) begin
                    if (mwe) clr = md[3:0];
                    else begin e_rd = {28'b0, mflag}; clr = 4'hF; end
                end else e_err = 1'b1;
            end
            mflag = (mflag & ~clr) | rise;
        end
    end

    always @(negedge clk) begin
        if (mok) begin
            chk("cyc_ready", rdy[0], ph == 0);
            chk("cyc_rsp_valid", rv[0], e_valid);
            chk("cyc_rsp_rdata", rdat[0], e_rd);
            chk("cyc_rsp_err", rerr[0], e_err);
            chk("cyc_out_data", od[0], {mout[3], mout[2], mout[1], mout[0]});
            chk("cyc_out_wstb", ws[0], e_ws);
        end
    end

    // Present one request to instance s, then follow it until the bridge is ready again
    task automatic access(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output logic [3:0] wsv,
                          output int lat, output int rlow);
        int n;
        @(negedge clk);
        we = w; addr = a; wdata = d; v[s] = 1'b1;
        n = 0;
        while (!rdy[s] && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 v[s] = 1'b0;
        lat = 0; rlow = 0; rd = '0; er = 1'b0; wsv = '0;
        while (!rdy[s] && rlow < 50) begin
            rlow++;
            if (rv[s] && lat == 0) begin lat = rlow; rd = rdat[s]; er = rerr[s]; wsv = ws[s]; end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        fails++;
        $display("FAIL watchdog: simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [3:0]  wv;
        int          lat, rl, base;
        logic [31:0] ea [3];
        ea = '{B + 32'h2, B + 32'h30, 32'h0000_1000};
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        chk("rst_ready", rdy, 3'b111);
        chk("rst_rsp_valid", rv, 3'b000);
        chk("rst_rsp_err", rerr, 3'b000);
        chk("rst_rdata", rdat[0], 32'h0);
        chk("rst_out_data", od[0], 128'h0);
        chk("rst_wstb", ws[0], 4'h0);

        access(0, 1'b1, B + 32'h4, 32'hA5, rd, er, wv, lat, rl);
        chk("st_latency", lat, 2);
        chk("st_err", er, 1'b0);
        chk("st_wstb", wv, 4'b0010);
        chk("st_out1", od[0][63:32], 32'hA5);
        access(0, 1'b0, B + 32'h4, 32'h0, rd, er, wv, lat, rl);
        chk("ld_out1", rd, 32'hA5);
        chk("ld_out1_err", er, 1'b0);

        in_data = {32'h4444_4444, 32'h0000_0123, 32'h2222_2222, 32'h1111_1111};
        access(0, 1'b0, B + 32'h48, 32'h0, rd, er, wv, lat, rl);
        chk("ld_in2", rd, 32'h123);
        chk("ld_in2_err", er, 1'b0);
        access(0, 1'b1, B + 32'h48, 32'hDEAD, rd, er, wv, lat, rl);
        chk("st_in2_err", er, 1'b1);
        chk("st_in2_wstb", wv, 4'h0);
        chk("st_in2_out", od[0], {64'h0, 32'hA5, 32'h0});

        @(negedge clk) evt_in = 4'b0010;
        @(negedge clk);
        @(negedge clk) evt_in = 4'b0000;
        access(0, 1'b0, B + 32'h80, 32'h0, rd, er, wv, lat, rl);
        chk("evt_read1", rd, 32'h2);
        access(0, 1'b0, B + 32'h80, 32'h0, rd, er, wv, lat, rl);
        chk("evt_read2", rd, 32'h0);
        @(negedge clk);
        we = 1'b0; addr = B + 32'h80; v[0] = 1'b1;
        @(posedge clk);
        #1 v[0] = 1'b0;
        @(negedge clk) evt_in = 4'b0010;
        @(posedge clk);
        #1;
        chk("setwin_rsp", rv[0], 1'b1);
        chk("setwin_pre", rdat[0], 32'h0);
        @(posedge clk);
        #1;
        access(0, 1'b0, B + 32'h80, 32'h0, rd, er, wv, lat, rl);
        chk("setwin_flag", rd, 32'h2);

        @(negedge clk) evt_in = 4'b1000;
        @(negedge clk);
        @(negedge clk) evt_in = 4'b0000;
        access(0, 1'b1, B + 32'h80, 32'h1, rd, er, wv, lat, rl);
        chk("w1c_other_err", er, 1'b0);
        access(0, 1'b0, B + 32'h80, 32'h0, rd, er, wv, lat, rl);
        chk("w1c_other", rd, 32'h8);
        @(negedge clk) evt_in = 4'b1000;
        @(negedge clk);
        @(negedge clk) evt_in = 4'b0000;
        access(0, 1'b1, B + 32'h80, 32'h8, rd, er, wv, lat, rl);
        access(0, 1'b0, B + 32'h80, 32'h0, rd, er, wv, lat, rl);
        chk("w1c_cleared", rd, 32'h0);

        for (int i = 0; i < 3; i++) begin
            access(0, 1'b0, ea[i], 32'h0, rd, er, wv, lat, rl);
            chk("bad_addr_err", er, 1'b1);
            chk("bad_addr_rdata", rd, 32'h0);
        end

        access(1, 1'b0, B + 32'h40, 32'h0, rd, er, wv, lat, rl);
        chk("w0_latency", lat, 1);
        chk("w0_busy", rl, 1);
        chk("w0_rdata", rd, 32'h1111_1111);
        access(2, 1'b0, B + 32'h44, 32'h0, rd, er, wv, lat, rl);
        chk("w3_latency", lat, 4);
        chk("w3_busy", rl, 4);
        chk("w3_rdata", rd, 32'h2222_2222);
        base = npulse[2];
        @(negedge clk);
        we = 1'b0; addr = B + 32'h44; v[2] = 1'b1;
        repeat (10) @(posedge clk);
        #1 v[2] = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("w3_b2b_count", npulse[2] - base, 2);

        @(negedge clk) evt_in = 4'b0001;
        @(negedge clk) evt_in = 4'b0000;
        @(negedge clk);
        we = 1'b1; addr = B; wdata = 32'hFFFF; v[0] = 1'b1;
        @(posedge clk);
        #1 v[0] = 1'b0;
        base = npulse[0];
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("abort_ready", rdy[0], 1'b1);
        chk("abort_out", od[0], 128'h0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_rsp", npulse[0] - base, 0);
        chk("abort_out_later", od[0], 128'h0);
        access(0, 1'b0, B + 32'h80, 32'h0, rd, er, wv, lat, rl);
        chk("abort_flags", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
